// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: elastic pipelined comparator for FloPoCo floats {exc,sign,exp,frac}.
// Define FPCMP_MINMAX_EN to add the min_out/max_out ports.
module fp_compare_pipe #(
    parameter int WE     = 11,
    parameter int WF     = 17,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WE+WF+2:0] inA,
    input  logic [WE+WF+2:0] inB,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             less,
    output logic             equal,
    output logic             greater,
    output logic             unordered
`ifdef FPCMP_MINMAX_EN
    ,
    output logic [WE+WF+2:0] min_out,
    output logic [WE+WF+2:0] max_out
`endif
);
    localparam int W = WE + WF + 3;
`ifdef FPCMP_MINMAX_EN
    localparam int PW = 9 + 2 * W;
`else
    localparam int PW = 9;
`endif

    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("fp_compare_pipe: STAGES must be in 1..3");
    end

    logic          w_adv;
    logic [W-2:0]  w_ka, w_kb;
    logic [PW-1:0] w_p [0:STAGES-1];
    logic          w_v [0:STAGES-1];

    // A stalled output freezes every stage at once.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // Class-major key; zero and inf drop exp/frac so all zeros tie and all infs tie.
    assign w_ka = {inA[W-1:W-2], inA[W-4:0] & {(W-3){inA[W-1:W-2] == 2'b01}}};
    assign w_kb = {inB[W-1:W-2], inB[W-4:0] & {(W-3){inB[W-1:W-2] == 2'b01}}};

    assign w_v[0] = in_valid;
    assign w_p[0] = {
`ifdef FPCMP_MINMAX_EN
        inA, inB,
`endif
        op, w_ka < w_kb, w_ka == w_kb, inA[W-3], inB[W-3],
        (inA[W-1:W-2] == 2'b00) & (inB[W-1:W-2] == 2'b00),
        (&inA[W-1:W-2]) | (&inB[W-1:W-2])};

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        logic [PW-1:0] r_p;
        logic          r_v;
        // Compare-result register(s); bubbles travel as r_v=0.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_v <= 1'b0;
                r_p <= '0;
            end else if (w_adv) begin
                r_v <= w_v[k-1];
                r_p <= w_p[k-1];
            end
        end
        assign w_v[k] = r_v;
        assign w_p[k] = r_p;
    end

    logic [PW-1:0] w_f;
    logic [2:0]    w_op;
    logic          w_mlt, w_meq, w_sa, w_sb, w_zz, w_un;
    logic          w_lt, w_eq, w_gt, w_res;

    assign w_f = w_p[STAGES-1];
    assign {w_op, w_mlt, w_meq, w_sa, w_sb, w_zz, w_un} = w_f[8:0];

    // Signs flip the magnitude order; both-zero is equal whatever the signs.
    assign w_eq = ~w_un & (w_zz | ((w_sa == w_sb) & w_meq));
    assign w_lt = ~w_un & ~w_zz & ((w_sa != w_sb) ? w_sa : (w_sa ? ~(w_mlt | w_meq) : w_mlt));
    assign w_gt = ~w_un & ~w_eq & ~w_lt;

    // Predicate select; reserved codes yield 0.
    always_comb begin
        w_res = (w_op == 3'd0) ? w_lt :
                (w_op == 3'd1) ? (w_lt | w_eq) :
                (w_op == 3'd2) ? w_eq :
                (w_op == 3'd3) ? w_gt :
                (w_op == 3'd4) ? (w_gt | w_eq) :
                (w_op == 3'd5) ? ~w_eq : 1'b0;
    end

    // Output register; bubbles update flags too so nothing stale lingers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= 1'b0;
            less      <= 1'b0;
            equal     <= 1'b0;
            greater   <= 1'b0;
            unordered <= 1'b0;
        end else if (w_adv) begin
            out_valid <= w_v[STAGES-1];
            result    <= w_res;
            less      <= w_lt;
            equal     <= w_eq;
            greater   <= w_gt;
            unordered <= w_un;
        end
    end

`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] w_a, w_b, w_min, w_max, w_nan;

    assign {w_a, w_b} = w_f[PW-1:9];
    assign w_nan = {2'b11, {(W-2){1'b0}}};
    assign w_min = w_un ? w_nan : (w_gt ? w_b : w_a);
    assign w_max = w_un ? w_nan : (w_lt ? w_b : w_a);

    // Min/max registers, aligned with out_valid; ties pick A.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_out <= '0;
            max_out <= '0;
        end else if (w_adv) begin
            min_out <= w_min;
            max_out <= w_max;
        end
    end
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: scoreboard bench for fp_compare_pipe (WE=11, WF=17, STAGES=2).
module tb_fp_compare_pipe;
    localparam int WE = 11;
    localparam int WF = 17;
    localparam int ST = 2;
    localparam int W  = WE + WF + 3;

    localparam logic [W-1:0] P1 = 31'h27FE0000, P2 = 31'h28000000, N1 = 31'h37FE0000;
    localparam logic [W-1:0] PZ = 31'h00000000, NZ = 31'h10000000, PI = 31'h40000000;
    localparam logic [W-1:0] NAN = 31'h60000000;

    typedef struct packed {
        logic [4:0]   f;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic [2:0]   op = 3'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         result, less, equal, greater, unordered;
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] min_out, max_out;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   stall_seen = 0;
    logic hold_prev = 1'b0;
    logic [5:0] held;

    fp_compare_pipe #(.WE(WE), .WF(WF), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .less(less), .equal(equal), .greater(greater), .unordered(unordered)
`ifdef FPCMP_MINMAX_EN
        , .min_out(min_out), .max_out(max_out)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every output transfer, checks stall behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                n_cmp++;
                if ({out_valid, result, less, equal, greater, unordered} !== held) begin
                    n_err++;
                    $display("FAIL frozen: got %b required %b", {out_valid, result, less, equal, greater, unordered}, held);
                end
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL in_ready_stall: got %b required 0", in_ready);
                end
            end
            hold_prev = out_valid && !out_ready;
            held = {out_valid, result, less, equal, greater, unordered};
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got a result with an empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    if ({result, less, equal, greater, unordered} !== e.f) begin
                        n_err++;
                        $display("FAIL flags: got res/lt/eq/gt/un=%b required %b", {result, less, equal, greater, unordered}, e.f);
                    end
`ifdef FPCMP_MINMAX_EN
                    n_cmp++;
                    if (min_out !== e.mn || max_out !== e.mx) begin
                        n_err++;
                        $display("FAIL minmax: got %h/%h required %h/%h", min_out, max_out, e.mn, e.mx);
                    end
`endif
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                        input logic [4:0] f, input logic [W-1:0] mn, input logic [W-1:0] mx);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        inA = a;
        inB = b;
        op = o;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck at 0");
        end else begin
            exp_q.push_back('{f, mn, mx});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_flags", W'({result, less, equal, greater, unordered}), '0);
`ifdef FPCMP_MINMAX_EN
        chk("rst_min", min_out, '0);
        chk("rst_max", max_out, '0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;

        // flags order: {result, less, equal, greater, unordered}
        send(P1, P2, 3'd0, 5'b11000, P1, P2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("latency", W'(n), W'(ST));
        drain("t1");

        send(NZ, PZ, 3'd2, 5'b10100, NZ, NZ);
        send(N1, PZ, 3'd3, 5'b01000, N1, PZ);
        drain("t2");

        for (int i = 0; i < 6; i++)
            send(NAN, P1, 3'(i), (i == 5) ? 5'b10001 : 5'b00001, NAN, NAN);
        drain("t3");

        send(PI, P2, 3'd4, 5'b10010, P2, PI);
        send(P2, N1, 3'd1, 5'b00010, N1, P2);
        send(31'h00001234, NZ, 3'd2, 5'b10100, 31'h00001234, 31'h00001234);
        send(31'h40005678, PI, 3'd2, 5'b10100, 31'h40005678, 31'h40005678);
        drain("t4");

        fork
            begin
                send(P1, P1, 3'd2, 5'b10100, P1, P1);
                send(P2, P1, 3'd3, 5'b10010, P1, P2);
                send(N1, NZ, 3'd0, 5'b11000, N1, NZ);
                send(NZ, N1, 3'd4, 5'b10010, N1, NZ);
                send(PZ, PI, 3'd5, 5'b11000, PZ, PI);
                send(PI, NAN, 3'd0, 5'b00001, NAN, NAN);
                send(N1, N1, 3'd1, 5'b10100, N1, N1);
                send(P2, P2, 3'd6, 5'b00100, P2, P2);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("t5");
        chk("stall_cycles_seen", W'(stall_seen >= 3), W'(1));

        send(P2, P1, 3'd0, 5'b00010, P1, P2);
        send(PI, P1, 3'd3, 5'b10010, P1, PI);
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", W'(out_valid), '0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        send(P1, P2, 3'd3, 5'b01000, P1, P2);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
